conv5x5_relu: RTL and testbench
===============================

Name: conv5x5_relu

Overview:
- Single-channel 5x5 valid convolution with bias, ReLU and requantization, in front of the maxpooling stage.
- Takes a raster-order 8-bit pixel stream: a 28x28 image (state=0) or a 12x12 map (state=1).
- Produces a 24x24 or 8x8 8-bit stream on dout/ovalid, in the format maxpooling consumes directly.
- Weights and bias are loaded through a simple write port between frames.

Parameters:
SHIFT, 4, arithmetic right-shift applied after ReLU for requantization (0..15)
BW, 16, bias width (signed)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
state  input  1  frame size select: 0 = 28x28 in / 24x24 out, 1 = 12x12 in / 8x8 out
ivalid  input  1  din valid, one pixel per asserted cycle
din  input  8  unsigned pixel, raster order
wen  input  1  weight/bias write enable
waddr  input  5  0..24 = weight index (row*5+col), 25 = bias, 26..31 ignored
wdata  input  16  weights use wdata[7:0] as signed 8-bit; bias uses wdata[BW-1:0] signed
dout  output  8  unsigned result
ovalid  output  1  dout valid
frame_done  output  1  one-cycle pulse coincident with the last ovalid of a frame

Behaviour:
- Reset (async, rstn=0):
  - ovalid, frame_done and dout go to 0.
  - Row/column counters and pipeline valids clear.
  - All weights and bias clear to 0.
  - Line-buffer contents need not be cleared.
- Frame size:
  - W = 28 when state=0, 12 when state=1.
  - state is sampled on the first accepted pixel of a frame (row=col=0) and held for the whole frame; changes mid-frame are ignored.
- Input counters:
  - col increments on each ivalid cycle.
  - col wraps at W-1 to 0 and increments row.
  - After pixel (W-1, W-1), both counters return to 0 and the next ivalid starts a new frame.
  - ivalid may deassert for any number of cycles; nothing advances while ivalid=0.
- Line buffers: 4 rows of up to 28 pixels plus a 5x5 shift window. The window advances only on ivalid.
- Output generation:
  - A window is valid when the accepted pixel has row>=4 and col>=4.
  - Output (r,c) corresponds to the window whose top-left is input (r,c).
  - Count per frame is (W-4)^2: 576 or 64, in raster order.
- Arithmetic:
  - Each product is unsigned din x signed weight, giving 17-bit signed.
  - The 25 products are summed into 22-bit signed; the sign-extended bias is then added.
  - ReLU: if sum<0 the result is 0.
  - The result is then shifted right by SHIFT.
  - Saturate: values >255 output 255.
- Latency: ovalid asserts exactly 3 clk cycles after the ivalid cycle that delivered the window's bottom-right pixel. This is independent of input gaps; the pipeline runs every cycle.
- frame_done is high in the same cycle as the final ovalid (576th or 64th).
- Weight writes:
  - Accepted only when the block is idle: row=col=0 and no results in the pipeline.
  - wen while busy is ignored.
  - A write accepted in cycle t is used by any window completed after t.
- Reset mid-frame:
  - Aborts the frame; no further ovalid appears for it.
  - After rstn=1 the next ivalid pixel is (0,0) of a new frame.
  - Weights must be reloaded.
- ovalid never asserts for windows spanning a row wrap (col<4).

Test Plan:
- Weights all 1, bias 0, 28x28 image all 16, ivalid continuous, state=0 -> 576 outputs each 25 (400>>4). frame_done is coincident with the 576th output. First ovalid arrives 3 cycles after input pixel (4,4).
- Only w[12]=16, others 0, bias 0, pixel(r,c)=(r*28+c)%256 -> out(r,c)=pixel(r+2,c+2) for all 576 outputs.
- All weights 127, all pixels 255 -> every output saturates to 255. All weights -1 (wdata=16'h00FF), bias 0 -> every output 0 (ReLU).
- Weights 0, bias 100 -> all outputs 6. Then state=1 with a 12x12 frame -> exactly 64 outputs, frame_done on the 64th. Changing state mid-frame has no effect.
- Same as the first scenario but ivalid randomly low ~50% of cycles -> identical 576 values in the same order. A wen issued mid-frame leaves results unchanged.
- rstn pulsed low after 300 pixels -> ovalid=0 immediately and weights read 0. Reload weights and stream a full frame -> exactly 576 correct outputs.

Source files
------------

// File: rtl/conv5x5_relu.sv
// conv5x5_relu: 5x5 valid convolution + bias + ReLU + requantize over a raster pixel stream.
// Three-stage pipeline: window capture, multiply-accumulate, ReLU/shift/saturate.
module conv5x5_relu #(
  parameter int SHIFT = 4,
  parameter int BW    = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        state,
  input  logic        ivalid,
  input  logic [7:0]  din,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  output logic [7:0]  dout,
  output logic        ovalid,
  output logic        frame_done
);
  logic [4:0] row_q, row_d, col_q, col_d, wm1;
  logic big_q, big_d, sz, first, wrap_c, win_v, last, wr_ok;
  logic v1_q, l1_q, v2_q, l2_q;
  logic [7:0] lb_q [4][28];
  logic [7:0] win_q [5][5];
  logic [7:0] colv [5];
  logic signed [7:0] w_q [25];
  logic signed [BW-1:0] bias_q;
  logic signed [16:0] prod [25];
  logic signed [21:0] sum_c, acc_q, shv;

  // Frame size is latched on pixel (0,0) so mid-frame state changes are ignored.
  assign first  = row_q == 5'd0 && col_q == 5'd0;
  assign sz     = first ? state : big_q;
  assign wm1    = sz ? 5'd11 : 5'd27;
  assign wrap_c = col_q == wm1;
  assign win_v  = ivalid && row_q >= 5'd4 && col_q >= 5'd4;
  assign last   = ivalid && wrap_c && row_q == wm1;
  assign wr_ok  = wen && first && !v1_q && !v2_q;
  assign shv    = acc_q >>> SHIFT;

  always_comb begin
    big_d = ivalid ? sz : big_q;
    col_d = ivalid ? (wrap_c ? 5'd0 : col_q + 5'd1) : col_q;
    row_d = (ivalid && wrap_c) ? (row_q == wm1 ? 5'd0 : row_q + 5'd1) : row_q;
  end

  // New window column: four buffered rows above the current one, oldest on top.
  always_comb begin
    colv[4] = din;
    for (int r = 0; r < 4; r++) colv[r] = lb_q[3-r][col_q];
  end

  always_comb begin
    sum_c = 22'(bias_q);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        prod[r*5+c] = $signed({1'b0, win_q[r][c]}) * w_q[r*5+c];
        sum_c = sum_c + 22'(prod[r*5+c]);
      end
  end

  always_ff @(posedge clk) begin
    if (ivalid) begin
      lb_q[0][col_q] <= din;
      for (int k = 1; k < 4; k++) lb_q[k][col_q] <= lb_q[k-1][col_q];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][4] <= colv[r];
      end
    end
    if (v1_q) acc_q <= sum_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q      <= '0;
      col_q      <= '0;
      big_q      <= 1'b0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      ovalid     <= 1'b0;
      frame_done <= 1'b0;
      dout       <= '0;
      bias_q     <= '0;
      for (int i = 0; i < 25; i++) w_q[i] <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      big_q      <= big_d;
      v1_q       <= win_v;
      l1_q       <= last;
      v2_q       <= v1_q;
      l2_q       <= l1_q;
      ovalid     <= v2_q;
      frame_done <= l2_q;
      dout       <= !v2_q || acc_q[21] ? 8'd0 : (|shv[21:8] ? 8'd255 : shv[7:0]);
      if (wr_ok && waddr < 5'd25) w_q[waddr] <= wdata[7:0];
      if (wr_ok && waddr == 5'd25) bias_q <= wdata[BW-1:0];
    end
  end
endmodule

// File: tb/tb_conv5x5_relu.sv
// tb_conv5x5_relu: scoreboard bench; a direct convolution model predicts every output and its cycle.
`timescale 1ns/1ps
module tb_conv5x5_relu;
  localparam int SHIFT = 4;
  logic clk = 1'b0, rstn = 1'b1, state = 1'b0, ivalid = 1'b0, wen = 1'b0;
  logic [7:0] din = '0;
  logic [4:0] waddr = '0;
  logic [15:0] wdata = '0;
  logic [7:0] dout;
  logic ovalid, frame_done;

  conv5x5_relu #(.SHIFT(SHIFT), .BW(16)) dut (
    .clk(clk), .rstn(rstn), .state(state), .ivalid(ivalid), .din(din),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .dout(dout), .ovalid(ovalid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {int v; bit last; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int img [28][28];
  int wt [25];
  int bias = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (ovalid) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL extra_ovalid dout=%0d cyc=%0d need no output", dout, cyc);
        else begin
          e = sb.pop_front();
          if (dout !== 8'(e.v) || frame_done !== e.last || cyc !== e.due)
            $display("FAIL out got dout=%0d fd=%0b cyc=%0d need dout=%0d fd=%0b cyc=%0d",
                     dout, frame_done, cyc, e.v, e.last, e.due);
          else n_pass++;
        end
      end else if (frame_done !== 1'b0) begin
        n_chk++;
        $display("FAIL lone_frame_done got=%b need=0", frame_done);
      end
    end
  end

  function automatic int model(int r, int c);
    int s = bias;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) s += img[r+i][c+j] * wt[i*5+j];
    if (s < 0) return 0;
    s = s >>> SHIFT;
    return s > 255 ? 255 : s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, int d);
    step();
    wen = 1'b1; waddr = 5'(a); wdata = 16'(d);
    step();
    wen = 1'b0;
  endtask

  task automatic load(int wv, int b);
    logic signed [7:0] s8;
    s8 = 8'(wv);
    for (int i = 0; i < 25; i++) begin
      wr(i, wv);
      wt[i] = int'(s8);
    end
    wr(25, b);
    bias = b;
  endtask

  task automatic fill_const(int v);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = (r * 28 + c) % 256;
  endtask

  task automatic send(int n, bit st, bit gaps, bit flip, int wen_at, int lim);
    int k = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (k < lim) begin
          if (gaps)
            while ($urandom_range(1) == 1) begin
              step();
              ivalid = 1'b0; wen = 1'b0;
            end
          step();
          ivalid = 1'b1;
          din = 8'(img[r][c]);
          state = (flip && k > 0) ? !st : st;
          wen = (k == wen_at); waddr = '0; wdata = 16'h0005;
          if (r >= 4 && c >= 4) sb.push_back('{model(r-4, c-4), r == n-1 && c == n-1, cyc + 3});
          k++;
        end
    step();
    ivalid = 1'b0; wen = 1'b0; state = st;
  endtask

  task automatic drain(string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    n_chk++;
    if (sb.size() != 0) $display("FAIL %s pending=%0d need 0", name, sb.size());
    else n_pass++;
    repeat (2) step();
  endtask

  task automatic chk_idle(string name);
    n_chk++;
    if (ovalid !== 1'b0 || frame_done !== 1'b0 || dout !== 8'd0)
      $display("FAIL %s got ov=%b fd=%b dout=%0d need 0/0/0", name, ovalid, frame_done, dout);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1 chk_idle("reset_async");
    repeat (3) step();
    chk_idle("reset_hold");
    rstn = 1'b1;
    repeat (2) step();
    chk_idle("reset_release");
  endtask

  task automatic test_ones();
    load(1, 0);
    fill_const(16);
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("ones");
  endtask

  task automatic test_center();
    load(0, 0);
    wr(12, 16);
    wt[12] = 16;
    fill_ramp();
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("center");
  endtask

  task automatic test_saturate_relu();
    load(127, 0);
    fill_const(255);
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("saturate");
    load(8'hFF, 0);
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("relu");
  endtask

  task automatic test_bias_small();
    load(0, 100);
    fill_ramp();
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("bias28");
    send(12, 1'b1, 1'b0, 1'b1, -1, 144);
    drain("bias12_flip");
  endtask

  task automatic test_gaps();
    load(1, 0);
    fill_ramp();
    send(28, 1'b0, 1'b1, 1'b0, 300, 784);
    drain("gaps_wen");
  endtask

  task automatic test_reset_mid();
    load(1, 0);
    fill_const(16);
    send(28, 1'b0, 1'b0, 1'b0, -1, 300);
    rstn = 1'b0;
    #1 chk_idle("midreset");
    sb.delete();
    for (int i = 0; i < 25; i++) wt[i] = 0;
    bias = 0;
    step();
    rstn = 1'b1;
    send(12, 1'b1, 1'b0, 1'b0, -1, 144);
    drain("weights_cleared");
    load(1, 0);
    send(28, 1'b0, 1'b0, 1'b0, -1, 784);
    drain("after_reload");
  endtask

  initial begin
    test_reset();
    test_ones();
    test_center();
    test_saturate_relu();
    test_bias_small();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
